// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared states, AXI constants and size helper for the burst read master
package axi_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ADDR,
    DATA,
    DONE
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI bursts must never cross a 4 KB page
  localparam int unsigned BOUNDARY_4K = 4096;

  // Byte-lane count to AxSIZE / address shift
  function automatic int size_log2(input int bytes);
    return $clog2(bytes);
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// rtl/axi_burst_calc.sv - min of remaining beats, max burst length and beats left in the 4 KB page
module axi_burst_calc
  import axi_rd_pkg::*;
#(
  parameter int C_LEN_WIDTH = 32,
  parameter int C_BURST_LEN = 16,
  parameter int C_BYTES     = 4
) (
  input  logic [11:0]            i_addr,
  input  logic [C_LEN_WIDTH-1:0] i_beats_left,
  output logic [8:0]             o_beats
);

  localparam int SHIFT = size_log2(C_BYTES);
  localparam int CW    = (C_LEN_WIDTH > 13) ? C_LEN_WIDTH : 13;

  logic [12:0]   w_page_bytes;
  logic [CW-1:0] w_left;
  logic [CW-1:0] w_cap;
  logic [CW-1:0] w_room;
  logic [CW-1:0] w_min_a;
  logic [CW-1:0] w_min;

  // Address is beat-aligned, so the page remainder divides exactly into beats
  assign w_page_bytes = 13'(BOUNDARY_4K) - {1'b0, i_addr};
  assign w_left       = CW'(i_beats_left);
  assign w_cap        = CW'(C_BURST_LEN);
  assign w_room       = CW'(w_page_bytes >> SHIFT);

  // Three-way minimum; result never exceeds C_BURST_LEN (<= 256) so 9 bits hold it
  always_comb begin
    w_min_a = (w_left < w_cap) ? w_left : w_cap;
    w_min   = (w_min_a < w_room) ? w_min_a : w_room;
    o_beats = 9'(w_min);
  end

endmodule

// File: rtl/axi_burst_read_master.sv
// rtl/axi_burst_read_master.sv - AXI4 read master streaming a region into a FIFO; optional AXI_RD_ERR_CHECK_EN
module axi_burst_read_master
  import axi_rd_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_LEN_WIDTH        = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [C_LEN_WIDTH-1:0]        i_total_len,
  output logic                          o_busy,
  output logic                          o_read_done,
  output logic                          o_err,
  output logic                          o_fifo_push,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
  input  logic                          i_fifo_full,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int LW    = C_LEN_WIDTH;
  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int SHIFT = size_log2(BYTES);
  localparam logic [AW-1:0] ADDR_ALIGN_MASK = ~(AW'(BYTES - 1));

  rd_state_t     r_state;
  logic          r_busy;
  logic          r_read_done;
  logic          r_arvalid;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_araddr;
  logic [7:0]    r_arlen;
  logic [LW-1:0] r_beats_left;
  logic [8:0]    r_burst_beats;
  logic [8:0]    r_beat_cnt;

  logic [8:0]    w_beats;
  logic [LW-1:0] w_len_beats;
  logic          w_rready;
  logic          w_beat_acc;
  logic          w_last_beat;
  logic [AW-1:0] w_burst_bytes;
  logic [LW-1:0] w_burst_beats_ext;

  axi_burst_calc #(
    .C_LEN_WIDTH (LW),
    .C_BURST_LEN (C_M_AXI_BURST_LEN),
    .C_BYTES     (BYTES)
  ) u_calc (
    .i_addr       (r_addr[11:0]),
    .i_beats_left (r_beats_left),
    .o_beats      (w_beats)
  );

  assign w_len_beats       = i_total_len >> SHIFT;
  assign w_burst_bytes     = AW'(r_burst_beats) << SHIFT;
  assign w_burst_beats_ext = LW'(r_burst_beats);

  // Backpressure must reach RREADY in the same cycle, so the data path stays combinational
  assign w_rready    = (r_state == DATA) && !i_fifo_full;
  assign w_beat_acc  = w_rready && M_AXI_RVALID;
  assign w_last_beat = (r_beat_cnt == 9'd1);

  assign M_AXI_RREADY  = w_rready;
  assign o_fifo_push   = w_beat_acc;
  assign o_r_data      = M_AXI_RDATA;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARSIZE  = 3'(SHIFT);
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARVALID = r_arvalid;
  assign o_busy        = r_busy;
  assign o_read_done   = r_read_done;

  // Transfer sequencer: split region into page-safe bursts, one outstanding at a time
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_read_done   <= 1'b0;
      r_arvalid     <= 1'b0;
      r_addr        <= '0;
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_beats_left  <= '0;
      r_burst_beats <= '0;
      r_beat_cnt    <= '0;
    end else begin
      r_read_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr       <= i_src_addr & ADDR_ALIGN_MASK;
            r_beats_left <= w_len_beats;
            r_busy       <= 1'b1;
            r_state      <= (w_len_beats == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          r_araddr      <= r_addr;
          r_arlen       <= 8'(w_beats - 9'd1);
          r_burst_beats <= w_beats;
          r_beat_cnt    <= w_beats;
          r_arvalid     <= 1'b1;
          r_state       <= ADDR;
        end
        ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_beat_acc) begin
            r_beat_cnt <= r_beat_cnt - 9'd1;
            if (w_last_beat) begin
              r_addr       <= r_addr + w_burst_bytes;
              r_beats_left <= r_beats_left - w_burst_beats_ext;
              r_state      <= (r_beats_left == w_burst_beats_ext) ? DONE : CALC;
            end
          end
        end
        DONE: begin
          r_read_done <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AXI_RD_ERR_CHECK_EN
  logic r_err;

  // Sticky error: bad response or RLAST out of step with our own beat count
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_err <= 1'b0;
    end else if (w_beat_acc) begin
      if ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RLAST != w_last_beat)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_resp;

  assign w_unused_resp = ^{M_AXI_RRESP, M_AXI_RLAST};
  assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb/tb_axi_burst_read_master.sv - directed bench for axi_burst_read_master with a one-burst AXI slave model
module tb_axi_burst_read_master;

`ifdef AXI_RD_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        M_AXI_ARESET;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        o_busy;
  logic        o_read_done;
  logic        o_err;
  logic        o_fifo_push;
  logic [31:0] o_r_data;
  logic        i_fifo_full;
  logic [0:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  axi_burst_read_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (M_AXI_ARESET),
    .i_start       (i_start),
    .i_src_addr    (i_src_addr),
    .i_total_len   (i_total_len),
    .o_busy        (o_busy),
    .o_read_done   (o_read_done),
    .o_err         (o_err),
    .o_fifo_push   (o_fifo_push),
    .o_r_data      (o_r_data),
    .i_fifo_full   (i_fifo_full),
    .M_AXI_ARID    (M_AXI_ARID),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_push_cyc = 0;
  int done_cyc = 0;
  int busy_at_1 = 0;
  int beat_total = 0;
  int err_beat = -1;

  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [31:0] push_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slave + FIFO monitor: handshakes decided at negedge (inputs stable), new beats driven after the edge
  initial begin : slave
    logic        active;
    logic [31:0] base;
    int          len;
    int          idx;
    active = 1'b0;
    base = '0;
    len = 0;
    idx = 0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA  = '0;
    M_AXI_RRESP  = 2'b00;
    M_AXI_RLAST  = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_ARESET) begin
        active = 1'b0;
      end else begin
        if (o_fifo_push) begin
          push_q.push_back(o_r_data);
          last_push_cyc = cyc;
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          idx++;
          beat_total++;
          if (idx > len) active = 1'b0;
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_addr_q.push_back(M_AXI_ARADDR);
          ar_len_q.push_back(M_AXI_ARLEN);
          active = 1'b1;
          base = M_AXI_ARADDR;
          len = int'(M_AXI_ARLEN);
          idx = 0;
        end
      end
      @(posedge clk);
      #1;
      if (active) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = base + 32'(4 * idx);
        M_AXI_RLAST  = (idx == len);
        M_AXI_RRESP  = (beat_total == err_beat) ? 2'b10 : 2'b00;
      end else begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = '0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RRESP  = 2'b00;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len);
    @(posedge clk);
    #1;
    ar_addr_q.delete();
    ar_len_q.delete();
    push_q.delete();
    beat_total = 0;
    i_src_addr  = addr;
    i_total_len = len;
    i_start     = 1'b1;
  endtask

  // Returns the number of edges after i_start was driven until o_read_done is seen, -1 on timeout
  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (i == 1) busy_at_1 = int'(o_busy);
      if (o_read_done) begin
        k = i;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] addr, input logic [7:0] len);
    if (idx < ar_addr_q.size()) begin
      check({tag, "_araddr"}, ar_addr_q[idx], addr);
      check({tag, "_arlen"}, ar_len_q[idx], len);
    end else begin
      check({tag, "_ar_missing"}, ar_addr_q.size(), idx + 1);
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    int nbad;
    nbad = 0;
    check({tag, "_push_count"}, push_q.size(), n);
    for (int i = 0; i < push_q.size() && i < n; i++) begin
      if (push_q[i] !== base + 32'(4 * i)) nbad++;
    end
    check({tag, "_push_data_bad"}, nbad, 0);
  endtask

  initial begin : main
    int k;
    int seen;
    M_AXI_ARESET  = 1'b1;
    i_start       = 1'b0;
    i_src_addr    = '0;
    i_total_len   = '0;
    i_fifo_full   = 1'b0;
    M_AXI_ARREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_read_done, 0);
    check("rst_err", o_err, 0);
    check("rst_push", o_fifo_push, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_rready", M_AXI_RREADY, 0);
    check("rst_araddr", M_AXI_ARADDR, 0);
    check("rst_arlen", M_AXI_ARLEN, 0);
    check("arsize", M_AXI_ARSIZE, 3'd2);
    check("arburst", M_AXI_ARBURST, 2'b01);
    check("arid", M_AXI_ARID, 0);
    M_AXI_ARESET = 1'b0;

    // single aligned burst
    start_xfer(32'h0000_1000, 32'd64);
    wait_done(200, k);
    check("t1_done_seen", (k > 0), 1);
    check("t1_busy_early", busy_at_1, 1);
    check("t1_busy_at_done", o_busy, 0);
    check("t1_ar_count", ar_addr_q.size(), 1);
    check_ar("t1_b0", 0, 32'h0000_1000, 8'd15);
    check_stream("t1", 32'h0000_1000, 16);
    check("t1_done_after_last", done_cyc - last_push_cyc, 2);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", o_read_done, 0);

    // 4 KB boundary split
    start_xfer(32'h0000_0FF0, 32'd64);
    wait_done(200, k);
    check("t2_done_seen", (k > 0), 1);
    check("t2_ar_count", ar_addr_q.size(), 2);
    check_ar("t2_b0", 0, 32'h0000_0FF0, 8'd3);
    check_ar("t2_b1", 1, 32'h0000_1000, 8'd11);
    check_stream("t2", 32'h0000_0FF0, 16);

    // short final burst, ARREADY held low for two cycles
    M_AXI_ARREADY = 1'b0;
    start_xfer(32'h0000_2000, 32'd100);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_arvalid_held", M_AXI_ARVALID, 1);
    check("t3_araddr_held", M_AXI_ARADDR, 32'h0000_2000);
    check("t3_arlen_held", M_AXI_ARLEN, 8'd15);
    M_AXI_ARREADY = 1'b1;
    wait_done(300, k);
    check("t3_done_seen", (k > 0), 1);
    check("t3_ar_count", ar_addr_q.size(), 2);
    check_ar("t3_b0", 0, 32'h0000_2000, 8'd15);
    check_ar("t3_b1", 1, 32'h0000_2040, 8'd8);
    check_stream("t3", 32'h0000_2000, 25);

    // zero length
    start_xfer(32'h0000_3000, 32'd0);
    wait_done(20, k);
    check("t4_done_latency", k, 2);
    check("t4_ar_count", ar_addr_q.size(), 0);
    check("t4_push_count", push_q.size(), 0);

    // FIFO backpressure mid-burst
    start_xfer(32'h0000_3000, 32'd32);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (push_q.size() >= 3) begin
        seen = 1;
        break;
      end
    end
    check("t5_reached_mid", seen, 1);
    i_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_rready_low", M_AXI_RREADY, 0);
      check("t5_push_low", o_fifo_push, 0);
      check("t5_rvalid_pending", M_AXI_RVALID, 1);
      @(posedge clk);
      #1;
    end
    i_fifo_full = 1'b0;
    wait_done(200, k);
    check("t5_done_seen", (k > 0), 1);
    check_stream("t5", 32'h0000_3000, 8);

    // error response on the third beat
    err_beat = 2;
    start_xfer(32'h0000_4000, 32'd32);
    wait_done(200, k);
    err_beat = -1;
    check("t6_done_seen", (k > 0), 1);
    check_stream("t6", 32'h0000_4000, 8);
    check("t6_err_set", o_err, ERR_EN);
    repeat (3) @(posedge clk);
    #1;
    check("t6_err_sticky", o_err, ERR_EN);
    start_xfer(32'h0000_6000, 32'd16);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check("t6_err_cleared", o_err, 0);
    wait_done(200, k);
    check("t6b_done_seen", (k > 0), 1);
    check_stream("t6b", 32'h0000_6000, 4);

    // reset during DATA
    start_xfer(32'h0000_5000, 32'd64);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (push_q.size() >= 2) begin
        seen = 1;
        break;
      end
    end
    check("t7_reached_data", seen, 1);
    M_AXI_ARESET = 1'b1;
    @(posedge clk);
    #1;
    check("t7_busy", o_busy, 0);
    check("t7_done", o_read_done, 0);
    check("t7_err", o_err, 0);
    check("t7_push", o_fifo_push, 0);
    check("t7_arvalid", M_AXI_ARVALID, 0);
    check("t7_rready", M_AXI_RREADY, 0);
    check("t7_araddr", M_AXI_ARADDR, 0);
    check("t7_arlen", M_AXI_ARLEN, 0);
    M_AXI_ARESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (o_read_done || o_busy) seen = 1;
    end
    check("t7_no_done_after_reset", seen, 0);

    // address wrap across 2^32, also a page split
    start_xfer(32'hFFFF_FFF8, 32'd16);
    wait_done(200, k);
    check("t8_done_seen", (k > 0), 1);
    check("t8_ar_count", ar_addr_q.size(), 2);
    check_ar("t8_b0", 0, 32'hFFFF_FFF8, 8'd1);
    check_ar("t8_b1", 1, 32'h0000_0000, 8'd1);
    check_stream("t8", 32'hFFFF_FFF8, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
